forwarding_unit_multi: RTL
==========================

# forwarding_unit_multi

Parametrised operand-forwarding and hazard unit for the pipelined datapath. It tracks the destination registers of the last DEPTH in-flight instructions and selects, per read port, the youngest matching pipeline stage as the bypass source. It raises a load-use stall when a result is not yet available, and supports an interlock-only mode with forwarding disabled. It sits beside the decode stage, driving the operand multiplexers and the decode-stage hold.

## Interface
- ADDR_W, 4, register address width
- NUM_READ, 2, number of read ports (operands)
- DEPTH, 3, number of tracked in-flight write stages (≥1); stage 0 = youngest (EX), stage DEPTH-1 = oldest
- ZERO_REG, 1, when 1, address 0 never matches (hard-wired zero register)
- SEL_W (derived), $clog2(DEPTH+1), width of each select field
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fwd_enable  in  1  1 = forwarding mode, 0 = interlock-only mode
- issue_valid  in  1  decode instruction requests to advance this cycle
- issue_wr_en  in  1  decode instruction writes a register
- issue_wr_addr  in  ADDR_W  its destination
- issue_is_load  in  1  its result comes from memory (available one stage late)
- flush  in  1  kill the decode instruction and the stage-0 entry
- rd_en  in  NUM_READ  per-port read-valid
- rd_addr  in  NUM_READ*ADDR_W  per-port source address, port p at [p*ADDR_W +: ADDR_W]
- fwd_sel  out  NUM_READ*SEL_W  port p: 0 = register file, k+1 = bypass from stage k
- stall  out  1  hold decode, insert bubble
- stall_count  out  16  saturating count of stall cycles

## Operation
- Tracking pipeline: DEPTH entries {v, addr, ld}, reset to all zero.
- Match(p,k): rd_en[p] & v[k] & (rd_addr[p]==addr[k]) & !(ZERO_REG & rd_addr[p]==0).
- Forwarding mode (fwd_enable=1):
  - fwd_sel[p] = k+1 for the lowest k with Match(p,k), else 0.
  - stall = issue_valid & OR over p of (Match(p,0) & ld[0]).
  - A load in stage 0 that shadows an older match still stalls; the youngest match always wins.
- Interlock mode (fwd_enable=0):
  - fwd_sel all 0.
  - stall = issue_valid & any Match(p,k) for any k.
- Update at each rising clock edge:
  - stage k <= stage k-1 for k≥1, unconditionally (older instructions always drain).
  - stage 0 <= {issue_wr_en, issue_wr_addr, issue_is_load} if issue_valid & !stall & !flush, else bubble (v=0).
  - flush also clears v[0] before the shift, so the killed entry never propagates. Stages ≥1 are unaffected.
- stall_count increments on each cycle with stall=1 and saturates at 0xFFFF. It is cleared only by reset.
- Reset asserted mid-operation: all entries invalidated immediately (asynchronously), fwd_sel→0, stall→0, stall_count→0.

## Timing
- fwd_sel and stall are combinational from the current entries and inputs: zero-cycle latency, valid in the same cycle as rd_addr.
- Entry write: an instruction issued at edge N occupies stage 0 after N, and stage k after N+k. It leaves tracking after edge N+DEPTH.
- Load-use: a stall lasts exactly one cycle. After the bubble the load is in stage 1, and fwd_sel = 2 for the dependent port.
- Reset values: fwd_sel=0, stall=0, stall_count=0. Forwarding cannot occur before the first valid issue after reset deasserts.
- Reset deassertion is synchronised externally. The first edge after deassertion performs a normal update.
- Simultaneous events:
  - flush with issue_valid: flush wins, bubble inserted.
  - stall with flush: bubble, flush wins.
  - The same address in several stages selects the lowest k.

## Test plan
- Back-to-back RAW: issue write r5, next cycle read r5 on port 0 (fwd_enable=1) -> fwd_sel[0]=1, stall=0. One cycle later, with no newer writer, -> fwd_sel[0]=2.
- Load-use: issue load r3, next cycle read r3 with issue_valid=1 -> stall=1 for one cycle, stall_count=1. The following cycle gives fwd_sel=2, stall=0.
- Youngest-wins and zero reg: writes r7 at stages 2 and 0; port 1 reads r7 -> fwd_sel[1]=1. Write r0 then read r0 -> fwd_sel=0 (ZERO_REG=1).
- Interlock mode: fwd_enable=0, write r4, then read r4 -> stall held for DEPTH (3) cycles with fwd_sel=0, then released. stall_count=3.
- Flush: issue write r9 with flush=1, then read r9 -> no match, fwd_sel=0. Also flush with r9 in stage 0 -> entry gone next cycle.
- Async reset mid-stream: assert reset with 3 valid entries between edges -> fwd_sel=0 and stall=0 immediately, stall_count=0. Force 70000 stalls -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/forwarding_unit_multi_if.sv
// forwarding_unit_multi_if: decode-side bundle for the forwarding unit.
// The decode stage is master; the forwarding unit is slave.
interface forwarding_unit_multi_if #(
  parameter int ADDR_W   = 4,
  parameter int NUM_READ = 2,
  parameter int DEPTH    = 3,
  parameter int SEL_W    = $clog2(DEPTH + 1)
);
  logic                       fwd_enable;
  logic                       issue_valid;
  logic                       issue_wr_en;
  logic [ADDR_W-1:0]          issue_wr_addr;
  logic                       issue_is_load;
  logic                       flush;
  logic [NUM_READ-1:0]        rd_en;
  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [NUM_READ*SEL_W-1:0]  fwd_sel;
  logic                       stall;
  logic [15:0]                stall_count;

  modport master (
    output fwd_enable,
    output issue_valid,
    output issue_wr_en,
    output issue_wr_addr,
    output issue_is_load,
    output flush,
    output rd_en,
    output rd_addr,
    input  fwd_sel,
    input  stall,
    input  stall_count
  );

  modport slave (
    input  fwd_enable,
    input  issue_valid,
    input  issue_wr_en,
    input  issue_wr_addr,
    input  issue_is_load,
    input  flush,
    input  rd_en,
    input  rd_addr,
    output fwd_sel,
    output stall,
    output stall_count
  );
endinterface

// File: rtl/forwarding_unit_multi.sv
// forwarding_unit_multi: bypass select and load-use / interlock stall
// for the last DEPTH in-flight register writers.
module forwarding_unit_multi #(
  parameter int ADDR_W   = 4,
  parameter int NUM_READ = 2,
  parameter int DEPTH    = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  forwarding_unit_multi_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]               v_q;
  logic [DEPTH-1:0][ADDR_W-1:0]   addr_q;
  logic                           ld0_q;
  logic [NUM_READ-1:0][DEPTH-1:0] hit;
  logic [NUM_READ*SEL_W-1:0]      sel;
  logic                           stall;
  logic                           accept;
  logic [15:0]                    cnt_q;

  always_comb begin
    hit = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        hit[p][k] = bus.rd_en[p] & v_q[k] &
          (bus.rd_addr[p*ADDR_W +: ADDR_W] == addr_q[k]) &
          !(ZERO_REG &&
            (bus.rd_addr[p*ADDR_W +: ADDR_W] == '0));
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel = '0;
    if (bus.fwd_enable) begin
      for (int p = 0; p < NUM_READ; p++) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (hit[p][k]) begin
            sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (bus.fwd_enable) begin
        stall = stall | (hit[p][0] & ld0_q);
      end else begin
        stall = stall | (|hit[p]);
      end
    end
    stall = stall & bus.issue_valid;
  end

  assign accept = bus.issue_valid & ~stall & ~bus.flush;

  // A load is only late while in stage 0, so older
  // stages need no load flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q    <= '0;
      addr_q <= '0;
      ld0_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v_q[k]    <= (k == 1) ? (v_q[k-1] & ~bus.flush)
                              : v_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
      v_q[0]    <= accept & bus.issue_wr_en;
      addr_q[0] <= accept ? bus.issue_wr_addr : '0;
      ld0_q     <= accept & bus.issue_is_load;
      if (stall && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.fwd_sel     = sel;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt_q;
endmodule
